// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, idle lane values and the write sequencer state type.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP   = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

  localparam logic [1:0]  IDLE_BANK    = 2'b11;
  localparam logic [12:0] IDLE_ADDR    = 13'h1fff;
  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

  typedef enum logic [2:0] {
    W_IDLE, W_ACT, W_TRCD, W_WR, W_BST, W_PRE, W_TRP, W_END
  } wr_state_t;

endpackage

// File: rtl/sdram_write.sv
// Single-job SDRAM write sequencer: ACTIVE, WRITE + data burst, BURST STOP, PRECHARGE.
// state  | meaning
// W_IDLE | waiting for a pending job and arbiter grant
// W_ACT  | ACTIVE on latched bank/row
// W_TRCD | tRCD NOP gap
// W_WR   | WRITE on first cycle, FIFO words driven on DQ every cycle
// W_BST  | BURST STOP ends the full-page burst
// W_PRE  | PRECHARGE all banks
// W_TRP  | tRP NOP gap
// W_END  | one-cycle completion pulse
module sdram_write
  import sdram_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int TRCD      = 2,
  parameter int TRP       = 2
) (
  input  logic        wr_clk,
  input  logic        wr_rst,
  input  logic        wr_trig,
  input  logic [1:0]  wr_bank_in,
  input  logic [12:0] wr_row_in,
  input  logic [8:0]  wr_col_in,
  input  logic [15:0] wr_fifo_data,
  input  logic        wr_en,
  output logic        wr_busy,
  output logic        wr_data_ack,
  output logic        wr_req,
  output logic        wr_end,
  output logic [3:0]  wr_sdram_cmd,
  output logic [1:0]  wr_sdram_bank,
  output logic [12:0] wr_sdram_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [9:0] TRCD_LAST = 10'(TRCD - 1);
  localparam logic [9:0] BL_LAST   = 10'(BURST_LEN - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP - 1);

  wr_state_t   state;
  logic [9:0]  cnt;
  logic        pending;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;

  assign wr_busy       = pending | (state != W_IDLE);
  assign wr_req        = pending;
  assign wr_data_ack   = wr_sdram_en;
  // Show-ahead FIFO: the head word is already valid in the cycle it is acked.
  assign wr_sdram_data = wr_sdram_en ? wr_fifo_data : 16'h0000;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state         <= W_IDLE;
      cnt           <= '0;
      pending       <= 1'b0;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      wr_end        <= 1'b0;
      wr_sdram_en   <= 1'b0;
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= IDLE_BANK;
      wr_sdram_addr <= IDLE_ADDR;
    end else begin
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= IDLE_BANK;
      wr_sdram_addr <= IDLE_ADDR;
      wr_sdram_en   <= 1'b0;
      wr_end        <= 1'b0;
      cnt           <= cnt + 10'd1;

      if (wr_trig && !wr_busy) begin
        pending <= 1'b1;
        bank_q  <= wr_bank_in;
        row_q   <= wr_row_in;
        col_q   <= wr_col_in;
      end

      case (state)
        W_IDLE: if (wr_en && pending) begin
          pending       <= 1'b0;
          state         <= W_ACT;
          wr_sdram_cmd  <= CMD_ACTIVE;
          wr_sdram_bank <= bank_q;
          wr_sdram_addr <= row_q;
        end
        W_ACT: begin
          state <= W_TRCD;
          cnt   <= '0;
        end
        W_TRCD: if (cnt == TRCD_LAST) begin
          state         <= W_WR;
          cnt           <= '0;
          wr_sdram_cmd  <= CMD_WRITE;
          wr_sdram_bank <= bank_q;
          wr_sdram_addr <= {4'b0000, col_q};
          wr_sdram_en   <= 1'b1;
        end
        W_WR: begin
          if (cnt == BL_LAST) begin
            state        <= W_BST;
            wr_sdram_cmd <= CMD_BURST_STOP;
          end else begin
            wr_sdram_en <= 1'b1;
          end
        end
        W_BST: begin
          state         <= W_PRE;
          wr_sdram_cmd  <= CMD_PRECHARGE;
          wr_sdram_addr <= PRE_ALL_ADDR;
        end
        W_PRE: begin
          state <= W_TRP;
          cnt   <= '0;
        end
        W_TRP: if (cnt == TRP_LAST) begin
          state  <= W_END;
          wr_end <= 1'b1;
        end
        W_END:   state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// Directed + randomized bench for sdram_write: two instances (default and minimum timing).
module tb_sdram_write;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRC = 4'b0100,
                         BST = 4'b0110, PRE = 4'b0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig[2];
  logic [1:0]  bank_in[2];
  logic [12:0] row_in[2];
  logic [8:0]  col_in[2];
  logic [15:0] fifo_data[2];
  logic        en[2];
  logic        busy[2], ack[2], req[2], wend[2], sen[2];
  logic [3:0]  cmd[2];
  logic [1:0]  sbank[2];
  logic [12:0] saddr[2];
  logic [15:0] sdata[2];

  int bl_p[2]   = '{8, 1};
  int trcd_p[2] = '{2, 1};
  int trp_p[2]  = '{2, 1};

  int checks = 0;
  int errors = 0;
  int cur_lane = 0;
  int cur_t = 0;

  // FIFO model: head word = base + number of pops so far
  logic [15:0] fifo_base[2];
  int unsigned pops[2] = '{0, 0};
  always @(posedge clk) begin
    if (ack[0]) pops[0] <= pops[0] + 1;
    if (ack[1]) pops[1] <= pops[1] + 1;
  end
  assign fifo_data[0] = fifo_base[0] + 16'(pops[0]);
  assign fifo_data[1] = fifo_base[1] + 16'(pops[1]);

  always #5 clk = ~clk;

  sdram_write u_dut0 (
    .wr_clk(clk), .wr_rst(rst), .wr_trig(trig[0]), .wr_bank_in(bank_in[0]),
    .wr_row_in(row_in[0]), .wr_col_in(col_in[0]), .wr_fifo_data(fifo_data[0]),
    .wr_en(en[0]), .wr_busy(busy[0]), .wr_data_ack(ack[0]), .wr_req(req[0]),
    .wr_end(wend[0]), .wr_sdram_cmd(cmd[0]), .wr_sdram_bank(sbank[0]),
    .wr_sdram_addr(saddr[0]), .wr_sdram_en(sen[0]), .wr_sdram_data(sdata[0])
  );

  sdram_write #(.BURST_LEN(1), .TRCD(1), .TRP(1)) u_dut1 (
    .wr_clk(clk), .wr_rst(rst), .wr_trig(trig[1]), .wr_bank_in(bank_in[1]),
    .wr_row_in(row_in[1]), .wr_col_in(col_in[1]), .wr_fifo_data(fifo_data[1]),
    .wr_en(en[1]), .wr_busy(busy[1]), .wr_data_ack(ack[1]), .wr_req(req[1]),
    .wr_end(wend[1]), .wr_sdram_cmd(cmd[1]), .wr_sdram_bank(sbank[1]),
    .wr_sdram_addr(saddr[1]), .wr_sdram_en(sen[1]), .wr_sdram_data(sdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane=%0d t=%0d observed=%0h expected=%0h", tag, cur_lane, cur_t, obs, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    cur_lane = i;
    chk("rst_cmd",  32'(cmd[i]),   32'(NOP));
    chk("rst_bank", 32'(sbank[i]), 32'h3);
    chk("rst_addr", 32'(saddr[i]), 32'h1fff);
    chk("rst_sen",  32'(sen[i]),   0);
    chk("rst_ack",  32'(ack[i]),   0);
    chk("rst_req",  32'(req[i]),   0);
    chk("rst_busy", 32'(busy[i]),  0);
    chk("rst_end",  32'(wend[i]),  0);
    chk("rst_data", 32'(sdata[i]), 0);
  endtask

  // Runs one job on lane i starting in the current cycle. poke_t: cycle (relative
  // to ACTIVE) in which a foreign trig is pulsed; abort_t: cycle at which reset hits.
  task automatic run_job(input int i, input logic [1:0] b, input logic [12:0] r,
                         input logic [8:0] c, input int gap, input int poke_t,
                         input int abort_t);
    int bl, trcd, trp, len, w0, bst_t;
    logic [15:0] head;
    logic [3:0]  e_cmd;
    logic [1:0]  e_bank;
    logic [12:0] e_addr;
    logic        chk_bank, chk_addr, e_en, e_end;
    bl = bl_p[i]; trcd = trcd_p[i]; trp = trp_p[i];
    len = 4 + trcd + bl + trp;
    w0 = trcd + 1;
    bst_t = trcd + bl + 1;
    head = 16'h0;
    cur_lane = i; cur_t = -1;
    trig[i] = 1'b1; bank_in[i] = b; row_in[i] = r; col_in[i] = c;
    @(negedge clk);
    trig[i] = 1'b0;
    chk("req_after_trig", 32'(req[i]), 1);
    chk("busy_after_trig", 32'(busy[i]), 1);
    repeat (gap) begin
      @(negedge clk);
      chk("req_wait", 32'(req[i]), 1);
      chk("cmd_wait", 32'(cmd[i]), 32'(NOP));
    end
    en[i] = 1'b1;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == 0) head = fifo_base[i] + 16'(pops[i]);
      e_cmd = NOP; e_bank = 2'b11; e_addr = 13'h1fff;
      chk_bank = 1'b1; chk_addr = 1'b1; e_end = 1'b0;
      if (t == 0) begin
        e_cmd = ACT; e_bank = b; e_addr = r;
      end else if (t == w0) begin
        e_cmd = WRC; e_bank = b; e_addr = {4'b0000, c};
      end else if (t == bst_t) begin
        e_cmd = BST; chk_bank = 1'b0; chk_addr = 1'b0;
      end else if (t == bst_t + 1) begin
        e_cmd = PRE; e_addr = 13'h0400; chk_bank = 1'b0;
      end else if (t == len - 1) begin
        e_end = 1'b1;
      end
      e_en = (t >= w0) && (t < w0 + bl);
      chk("cmd", 32'(cmd[i]), 32'(e_cmd));
      if (chk_addr) chk("addr", 32'(saddr[i]), 32'(e_addr));
      if (chk_bank) chk("bank", 32'(sbank[i]), 32'(e_bank));
      chk("sdram_en", 32'(sen[i]), 32'(e_en));
      chk("data_ack", 32'(ack[i]), 32'(e_en));
      chk("wr_end", 32'(wend[i]), 32'(e_end));
      chk("busy_run", 32'(busy[i]), 1);
      chk("req_run", 32'(req[i]), 0);
      if (e_en) chk("data", 32'(sdata[i]), 32'(head + 16'(t - w0)));
      if (t == abort_t) begin
        rst = 1'b1;
        #1;
        chk_reset(i);
        @(negedge clk);
        rst = 1'b0; en[i] = 1'b0; trig[i] = 1'b0;
        return;
      end
      trig[i] = (t == poke_t);
      if (t == poke_t) row_in[i] = 13'h0456;
    end
    @(negedge clk);
    trig[i] = 1'b0;
    cur_t = len;
    chk("post_end", 32'(wend[i]), 0);
    chk("post_cmd", 32'(cmd[i]), 32'(NOP));
    chk("post_busy", 32'(busy[i]), 0);
    chk("post_req", 32'(req[i]), 0);
  endtask

  // Grant still high in the cycle after wr_end: must not restart.
  task automatic stale_check(input int i);
    cur_lane = i; cur_t = -2;
    @(negedge clk);
    chk("stale_cmd", 32'(cmd[i]), 32'(NOP));
    chk("stale_busy", 32'(busy[i]), 0);
    chk("stale_req", 32'(req[i]), 0);
    en[i] = 1'b0;
  endtask

  initial begin
    int lane, gap, len;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      trig[i] = 1'b0; en[i] = 1'b0; bank_in[i] = '0; row_in[i] = '0; col_in[i] = '0;
    end
    fifo_base[0] = 16'hA000;
    fifo_base[1] = 16'(($urandom & 32'hffff));
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(negedge clk);

    // nominal job with an ignored trig during the data burst
    run_job(0, 2'd1, 13'h0123, 9'h010, 2, 5, -1);
    stale_check(0);

    // minimum timing, then a back-to-back job in the cycle after wr_end
    run_job(1, 2'd2, 13'h1abc, 9'h1ff, 1, -1, -1);
    run_job(1, 2'(($urandom & 3)), 13'(($urandom & 32'h1fff)), 9'(($urandom & 32'h1ff)), 0, -1, -1);
    stale_check(1);

    for (int n = 0; n < 8; n++) begin
      lane = n % 2;
      gap = $urandom_range(0, 3);
      len = 4 + trcd_p[lane] + bl_p[lane] + trp_p[lane];
      fifo_base[lane] = 16'(($urandom & 32'hffff));
      @(negedge clk);
      run_job(lane, 2'(($urandom & 3)), 13'(($urandom & 32'h1fff)),
              9'(($urandom & 32'h1ff)), gap, $urandom_range(0, len - 1), -1);
      stale_check(lane);
    end

    // reset during the fourth W_WR cycle, then a clean job afterwards
    @(negedge clk);
    run_job(0, 2'd0, 13'h0077, 9'h020, 1, -1, trcd_p[0] + 1 + 3);
    cur_lane = 0; cur_t = -3;
    @(negedge clk);
    chk("after_abort_busy", 32'(busy[0]), 0);
    chk("after_abort_cmd", 32'(cmd[0]), 32'(NOP));
    run_job(0, 2'd3, 13'h1555, 9'h0aa, 0, -1, -1);
    stale_check(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
